// File: rtl/l2_arb_pkg.sv
// l2_arb_pkg: shared state, owner and L2 command encodings for the L2 port arbiter.
package l2_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RELEASE} arb_state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    localparam logic [1:0] L2_OP_NONE  = 2'd0;
    localparam logic [1:0] L2_OP_READ  = 2'd1;
    localparam logic [1:0] L2_OP_WRITE = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at its maximum instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb count_d = (inc && !(&count_q)) ? count_q + 1'b1 : count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: round-robin share of the L2 upstream port between icache and dcache,
// holding the winner's command stable until L2 responds.
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int S_LINE = 256,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [31:0]       i_address,
    output logic [S_LINE-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_address,
    input  logic [S_LINE-1:0] d_wdata,
    output logic [S_LINE-1:0] d_rdata,
    output logic              d_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [31:0]       l2_address,
    output logic [S_LINE-1:0] l2_wdata,
    input  logic [S_LINE-1:0] l2_rdata,
    input  logic              l2_resp,
    output logic [CNT_W-1:0]  i_grant_count,
    output logic [CNT_W-1:0]  d_grant_count
);

    arb_state_t        state_q, state_d;
    owner_t            last_q, last_d;
    logic [1:0]        op_q, op_d;
    logic [31:0]       addr_q, addr_d;
    logic [S_LINE-1:0] wdata_q, wdata_d;
    logic              d_req, grant_i, grant_d;

    assign d_req   = d_read | d_write;
    assign grant_i = (state_q == IDLE) && i_read && (!d_req || last_q == OWN_D);
    assign grant_d = (state_q == IDLE) && d_req && !grant_i;

    // op is cleared on the response so the command drops as RELEASE begins
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d = BUSY_I;
                    last_d  = OWN_I;
                    op_d    = L2_OP_READ;
                    addr_d  = i_address;
                    wdata_d = '0;
                end else if (grant_d) begin
                    state_d = BUSY_D;
                    last_d  = OWN_D;
                    op_d    = d_write ? L2_OP_WRITE : L2_OP_READ;
                    addr_d  = d_address;
                    wdata_d = d_wdata;
                end
            end
            BUSY_I, BUSY_D: begin
                state_d = l2_resp ? RELEASE : state_q;
                op_d    = l2_resp ? L2_OP_NONE : op_q;
            end
            default: begin
                state_d = IDLE;
                op_d    = L2_OP_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= OWN_D;
            op_q    <= L2_OP_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign l2_read    = (op_q == L2_OP_READ);
    assign l2_write   = (op_q == L2_OP_WRITE);
    assign l2_address = addr_q;
    assign l2_wdata   = wdata_q;
    assign i_resp     = (state_q == BUSY_I) && l2_resp;
    assign d_resp     = (state_q == BUSY_D) && l2_resp;
    assign i_rdata    = i_resp ? l2_rdata : '0;
    assign d_rdata    = d_resp ? l2_rdata : '0;

    sat_counter #(.W(CNT_W)) u_i_cnt (.clk(clk), .rst(rst), .inc(grant_i), .count(i_grant_count));
    sat_counter #(.W(CNT_W)) u_d_cnt (.clk(clk), .rst(rst), .inc(grant_d), .count(d_grant_count));

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb_l2_port_arbiter: vector table, directed corner sequences and a randomized run
// against a transaction-level model of the arbiter.
module tb_l2_port_arbiter;

    localparam int SL = 256;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_read, d_read, d_write, l2_resp;
    logic [31:0]   i_address, d_address;
    logic [SL-1:0] d_wdata, l2_rdata;
    logic [SL-1:0] i_rdata, d_rdata, l2_wdata;
    logic          i_resp, d_resp, l2_read, l2_write;
    logic [31:0]   l2_address;
    logic [CW-1:0] i_grant_count, d_grant_count;

    l2_port_arbiter #(.S_LINE(SL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
        .l2_rdata(l2_rdata), .l2_resp(l2_resp),
        .i_grant_count(i_grant_count), .d_grant_count(d_grant_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string n, input logic [1023:0] got, input logic [1023:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", n, got, exp);
        end
    endtask

    function automatic logic [SL-1:0] rep(input logic [7:0] b);
        return {32{b}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        i_read = 0; d_read = 0; d_write = 0; l2_resp = 0;
        i_address = '0; d_address = '0; d_wdata = '0; l2_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_in();
        tick();
        tick();
        rst = 0;
    endtask

    typedef struct {
        logic ir, dr, dw, lr;
        logic [31:0] ia, da;
        logic [7:0] wb, rb;
        logic e_rd, e_wr, e_ir, e_dr;
        logic [31:0] e_a;
        logic [7:0] e_wb;
        logic [1:0] e_ci, e_cd;
    } row_t;

    row_t rows[$];

    task automatic add(input logic ir, dr, dw, lr, input logic [31:0] ia, da,
                       input logic [7:0] wb, rb, input logic e_rd, e_wr, e_ir, e_dr,
                       input logic [31:0] e_a, input logic [7:0] e_wb, input logic [1:0] e_ci, e_cd);
        row_t r;
        r.ir = ir; r.dr = dr; r.dw = dw; r.lr = lr; r.ia = ia; r.da = da; r.wb = wb; r.rb = rb;
        r.e_rd = e_rd; r.e_wr = e_wr; r.e_ir = e_ir; r.e_dr = e_dr;
        r.e_a = e_a; r.e_wb = e_wb; r.e_ci = e_ci; r.e_cd = e_cd;
        rows.push_back(r);
    endtask

    // transaction-level reference: one pending command, one cooldown cycle, round-robin memory
    bit            m_tv, m_twr, m_cool;
    int            m_port, m_last, m_ci, m_cd;
    logic [31:0]   m_ta;
    logic [SL-1:0] m_twd;

    task automatic model_check(input int cyc);
        logic ir_e, dr_e;
        ir_e = m_tv && m_port == 0 && l2_resp;
        dr_e = m_tv && m_port == 1 && l2_resp;
        chk($sformatf("rnd%0d ctl", cyc),
            {l2_read, l2_write, i_resp, d_resp, i_grant_count, d_grant_count},
            {m_tv && !m_twr, m_tv && m_twr, ir_e, dr_e, CW'(m_ci), CW'(m_cd)});
        chk($sformatf("rnd%0d rdata", cyc), {i_rdata, d_rdata},
            {ir_e ? l2_rdata : {SL{1'b0}}, dr_e ? l2_rdata : {SL{1'b0}}});
        if (m_tv) chk($sformatf("rnd%0d cmd", cyc), {l2_address, l2_wdata}, {m_ta, m_twd});
    endtask

    task automatic model_step();
        bit ir, dr, win_d;
        ir = i_read;
        dr = d_read | d_write;
        if (m_tv) begin
            if (l2_resp) begin m_tv = 0; m_cool = 1; end
        end else if (m_cool) begin
            m_cool = 0;
        end else if (ir || dr) begin
            win_d  = dr && (!ir || m_last == 0);
            m_tv   = 1;
            m_port = win_d ? 1 : 0;
            m_twr  = win_d && d_write;
            m_ta   = win_d ? d_address : i_address;
            m_twd  = win_d ? d_wdata : '0;
            m_last = m_port;
            if (win_d) m_cd = (m_cd < CMAX) ? m_cd + 1 : CMAX;
            else       m_ci = (m_ci < CMAX) ? m_ci + 1 : CMAX;
        end
    endtask

    initial begin
        idle_in();
        //   ir dr dw lr  ia     da     wb     rb     rd wr ir dr  e_a    e_wb   ci cd
        add(1, 0, 0, 0, 32'h1000, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0,        8'h00, 0, 0);
        add(1, 0, 0, 0, 32'h1000, 0, 8'h00, 8'h00, 1, 0, 0, 0, 32'h1000, 8'h00, 1, 0);
        add(1, 0, 0, 0, 32'h1000, 0, 8'h00, 8'h00, 1, 0, 0, 0, 32'h1000, 8'h00, 1, 0);
        add(1, 0, 0, 0, 32'h1000, 0, 8'h00, 8'h00, 1, 0, 0, 0, 32'h1000, 8'h00, 1, 0);
        add(1, 0, 0, 1, 32'h1000, 0, 8'h00, 8'hA5, 1, 0, 1, 0, 32'h1000, 8'h00, 1, 0);
        add(0, 0, 0, 0, 0, 0,         8'h00, 8'h00, 0, 0, 0, 0, 0,        8'h00, 1, 0);
        add(0, 0, 0, 0, 0, 0,         8'h00, 8'h00, 0, 0, 0, 0, 0,        8'h00, 1, 0);
        add(0, 0, 1, 0, 0, 32'h2020,  8'h3C, 8'h00, 0, 0, 0, 0, 0,        8'h00, 1, 0);
        add(0, 0, 1, 0, 0, 32'h2020,  8'hC3, 8'h00, 0, 1, 0, 0, 32'h2020, 8'h3C, 1, 1);
        add(0, 0, 1, 0, 0, 32'h2020,  8'hC3, 8'h00, 0, 1, 0, 0, 32'h2020, 8'h3C, 1, 1);
        add(0, 0, 1, 1, 0, 32'h2020,  8'hC3, 8'h11, 0, 1, 0, 1, 32'h2020, 8'h3C, 1, 1);
        add(0, 0, 0, 0, 0, 0,         8'h00, 8'h00, 0, 0, 0, 0, 0,        8'h00, 1, 1);
        add(0, 0, 0, 1, 0, 0,         8'h00, 8'hEE, 0, 0, 0, 0, 0,        8'h00, 1, 1);
        add(1, 1, 0, 0, 32'h40, 32'h80, 8'h5A, 8'h00, 0, 0, 0, 0, 0,      8'h00, 1, 1);
        add(1, 1, 0, 0, 32'h40, 32'h80, 8'h5A, 8'h00, 1, 0, 0, 0, 32'h40, 8'h00, 2, 1);
        add(1, 1, 0, 1, 32'h40, 32'h80, 8'h5A, 8'h22, 1, 0, 1, 0, 32'h40, 8'h00, 2, 1);
        add(0, 1, 0, 1, 0, 32'h80,    8'h5A, 8'h99, 0, 0, 0, 0, 0,        8'h00, 2, 1);
        add(0, 1, 0, 0, 0, 32'h80,    8'h5A, 8'h00, 0, 0, 0, 0, 0,        8'h00, 2, 1);
        add(0, 1, 0, 0, 0, 32'h80,    8'h5A, 8'h00, 1, 0, 0, 0, 32'h80,   8'h5A, 2, 2);
        add(0, 1, 0, 1, 0, 32'h80,    8'h5A, 8'h33, 1, 0, 0, 1, 32'h80,   8'h5A, 2, 2);
        add(0, 0, 0, 0, 0, 0,         8'h00, 8'h00, 0, 0, 0, 0, 0,        8'h00, 2, 2);
        add(0, 1, 1, 0, 0, 32'h100,   8'h77, 8'h00, 0, 0, 0, 0, 0,        8'h00, 2, 2);
        add(0, 1, 1, 0, 0, 32'h100,   8'h77, 8'h00, 0, 1, 0, 0, 32'h100,  8'h77, 2, 3);
        add(0, 1, 1, 1, 0, 32'h100,   8'h77, 8'h44, 0, 1, 0, 1, 32'h100,  8'h77, 2, 3);
        add(0, 0, 0, 0, 0, 0,         8'h00, 8'h00, 0, 0, 0, 0, 0,        8'h00, 2, 3);
        add(0, 0, 0, 0, 0, 0,         8'h00, 8'h00, 0, 0, 0, 0, 0,        8'h00, 2, 3);

        do_reset();
        chk("reset ctl", {l2_read, l2_write, i_resp, d_resp, i_grant_count, d_grant_count}, '0);
        foreach (rows[k]) begin
            i_read = rows[k].ir; d_read = rows[k].dr; d_write = rows[k].dw; l2_resp = rows[k].lr;
            i_address = rows[k].ia; d_address = rows[k].da;
            d_wdata = rep(rows[k].wb); l2_rdata = rep(rows[k].rb);
            if (rows[k].dr && rows[k].dw)
                $display("note: row %0d drives d_read and d_write together (protocol violation, write expected to win)", k);
            #1;
            chk($sformatf("row%0d ctl", k),
                {l2_read, l2_write, i_resp, d_resp, i_grant_count, d_grant_count},
                {rows[k].e_rd, rows[k].e_wr, rows[k].e_ir, rows[k].e_dr, rows[k].e_ci, rows[k].e_cd});
            chk($sformatf("row%0d rdata", k), {i_rdata, d_rdata},
                {rows[k].e_ir ? rep(rows[k].rb) : {SL{1'b0}}, rows[k].e_dr ? rep(rows[k].rb) : {SL{1'b0}}});
            if (rows[k].e_rd || rows[k].e_wr)
                chk($sformatf("row%0d cmd", k), {l2_address, l2_wdata}, {rows[k].e_a, rep(rows[k].e_wb)});
            tick();
        end

        // asynchronous reset in the middle of a writeback
        do_reset();
        d_write = 1; d_address = 32'h2020; d_wdata = rep(8'h3C);
        tick();
        tick();
        l2_resp = 1; l2_rdata = rep(8'h66);
        #1;
        chk("pre-reset busy_d", {l2_write, d_resp, d_grant_count}, {1'b1, 1'b1, 2'd1});
        #1;
        rst = 1;
        #1;
        chk("async reset", {l2_read, l2_write, i_resp, d_resp, i_grant_count, d_grant_count}, '0);
        @(posedge clk);
        #1;
        rst = 0;
        idle_in();
        i_read = 1; d_read = 1; i_address = 32'h40; d_address = 32'h80;
        tick();
        chk("post-reset tie", {l2_read, l2_address, i_grant_count, d_grant_count}, {1'b1, 32'h40, 2'd1, 2'd0});

        // both ports held requesting: grants must alternate
        for (int t = 0; t < 6; t++) begin
            int w;
            w = 0;
            while (!l2_read && w < 8) begin tick(); w++; end
            chk($sformatf("contend%0d grant", t), {l2_read, l2_address}, {1'b1, (t % 2) ? 32'h80 : 32'h40});
            l2_resp = 1; l2_rdata = rep(8'(t));
            #1;
            chk($sformatf("contend%0d resp", t), {i_resp, d_resp}, (t % 2) ? 2'b01 : 2'b10);
            tick();
            l2_resp = 0;
        end

        // counter saturation with a 2-bit counter
        do_reset();
        for (int k = 0; k < 5; k++) begin
            i_read = 1; i_address = 32'h1000 + 32'(k);
            tick();
            chk($sformatf("sat grant%0d", k), i_grant_count, (k + 1 < CMAX) ? k + 1 : CMAX);
            l2_resp = 1;
            tick();
            l2_resp = 0; i_read = 0;
            tick();
        end

        // randomized traffic against the reference model
        do_reset();
        m_tv = 0; m_twr = 0; m_cool = 0; m_port = 0; m_last = 1; m_ci = 0; m_cd = 0;
        m_ta = '0; m_twd = '0;
        for (int c = 0; c < 400; c++) begin
            int op;
            op = $urandom_range(0, 2);
            i_read    = $urandom_range(0, 1);
            d_read    = (op == 1);
            d_write   = (op == 2);
            l2_resp   = ($urandom_range(0, 2) == 0);
            i_address = $urandom;
            d_address = $urandom;
            for (int j = 0; j < SL / 32; j++) begin
                d_wdata[j*32 +: 32]  = $urandom;
                l2_rdata[j*32 +: 32] = $urandom;
            end
            #1;
            model_check(c);
            model_step();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Shares the single upstream port of the unified L2 cache core between the icache miss path (read only) and the dcache miss/writeback path (read/write).
- Sits between the two pipelined L1 cache cores and the L2 core inside the cache hierarchy.
- Grants the port round-robin and latches the winner's request, so L2 sees a stable command until it responds.
- Keeps saturating per-port grant counters for performance visibility.

Parameters:
- S_LINE, 256, cache line width in bits.
- CNT_W, 16, width of each grant counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_read  in  1  icache line-fill request; held until i_resp
- i_address  in  32  icache line address
- i_rdata  out  S_LINE  fill data to icache
- i_resp  out  1  icache transaction complete
- d_read  in  1  dcache line-fill request; held until d_resp
- d_write  in  1  dcache writeback request; held until d_resp
- d_address  in  32  dcache line address
- d_wdata  in  S_LINE  writeback data
- d_rdata  out  S_LINE  fill data to dcache
- d_resp  out  1  dcache transaction complete
- l2_read  out  1  read command to L2
- l2_write  out  1  write command to L2
- l2_address  out  32  latched address
- l2_wdata  out  S_LINE  latched write data
- l2_rdata  in  S_LINE  L2 read data
- l2_resp  in  1  L2 transaction complete
- i_grant_count  out  CNT_W  number of icache grants, saturating
- d_grant_count  out  CNT_W  number of dcache grants, saturating

Behaviour:
- State machine states: IDLE, BUSY_I, BUSY_D, RELEASE.
- Reset, applied asynchronously:
  - state goes to IDLE.
  - last_owner goes to D.
  - All latches and counters clear to 0.
  - l2_read, l2_write, i_resp and d_resp are 0 immediately.
- IDLE:
  - If there is no request, stay in IDLE.
  - If exactly one port requests, grant it.
  - If both request, grant the port that is not last_owner.
  - On a grant:
    - Latch address, operation, and wdata. wdata is the dcache data, or 0 for icache.
    - Set last_owner to the winner and increment its counter.
    - Next state is BUSY_I or BUSY_D.
- Latency: a request seen in IDLE at cycle N gives l2_read/l2_write high at cycle N+1.
- BUSY_x:
  - Drive l2_read/l2_write/l2_address/l2_wdata from the latches only. Upstream input changes are ignored.
  - When l2_resp=1, assert x_resp=1 in the same cycle (combinational) and route l2_rdata to x_rdata. Next state is RELEASE.
  - The non-owner's resp stays 0.
- RELEASE:
  - Lasts one cycle. All L2 commands and all resp outputs are 0.
  - Next state is IDLE.
  - This cycle lets the served requester drop its request, so the same request is not issued twice.
- Minimum spacing between consecutive L2 commands: 2 idle cycles of l2_read/l2_write.
- i_rdata and d_rdata: equal l2_rdata whenever the matching resp is 1; otherwise 0.
- d_read and d_write both high: the write wins and the latched op is write. The bench flags this as a protocol violation.
- l2_resp while in IDLE or RELEASE: ignored, with no state change.
- Counters: increment by 1 per grant and hold at 2^CNT_W-1. They never wrap.
- Reset mid-transaction: the pending L2 command is abandoned and the arbiter returns to IDLE as described above.

Decomposition:
- Package l2_arb_pkg:
  - arb_state_t enum {IDLE, BUSY_I, BUSY_D, RELEASE}
  - owner_t enum {OWN_I, OWN_D}
  - L2_OP_NONE/READ/WRITE constants
- Sub-module sat_counter #(W): async reset, inc input, saturating output. Instantiated twice, once per grant counter.

Test Plan:
- Single icache read:
  - Stimulus: i_read=1, i_address=0x0000_1000 at cycle 0; L2 returns l2_resp with l2_rdata=0xA5..A5 at cycle 4.
  - Response: l2_read=1 with l2_address=0x1000 during cycles 1–4. i_resp=1 and i_rdata=0xA5..A5 at cycle 4. RELEASE at cycle 5, IDLE at cycle 6. i_grant_count=1.
- Simultaneous requests after reset:
  - Stimulus: i_read and d_read both asserted at cycle 0.
  - Response: icache is granted first. After its resp, the dcache request is latched in the next IDLE cycle. Both counters end at 1.
- Repeated contention:
  - Stimulus: both ports held requesting across 6 transactions.
  - Response: grants alternate I,D,I,D,I,D. No resp ever goes to the non-owner.
- Writeback:
  - Stimulus: d_write=1, d_address=0x2020, d_wdata=pattern P. Then change d_wdata to Q while in BUSY_D.
  - Response: l2_write=1 and l2_wdata stays P until l2_resp. d_resp pulses for exactly one cycle.
- Async reset mid-BUSY_D:
  - Stimulus: assert rst between clock edges.
  - Response: l2_write drops to 0 before the next edge. Both counters read 0. The first grant after reset goes to icache on a tie.
- Saturation:
  - Stimulus: CNT_W=2, 5 icache grants.
  - Response: i_grant_count reads 1,2,3,3,3.
